// File: rtl/dircc_hps_mailbox.sv
// HPS lightweight-bridge mailbox: Avalon-MM register window over a store-and-forward
// TX FIFO feeding the fabric stream and an RX FIFO filled from the fabric stream.
module dircc_hps_mailbox #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [DATA_W:0]         tx_mem [DEPTH];
  logic [DATA_W:0]         rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]           tx_count, rx_count, pkt_cnt;
  logic [CW-1:0]           tx_count_nxt, pkt_cnt_nxt;
  logic                    tx_overflow, rx_underflow, irq_en;
  logic                    tx_full, tx_empty, rx_full, rx_empty;
  logic                    wr_status, wr_tx, wr_end, rd_rx;
  logic                    tx_push, tx_end_push, tx_pop, tx_last_pop;
  logic                    rx_push, rx_pop, rx_head_last;
  logic [31:0]             status;

  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  assign wr_status = avs_write && (avs_address == 2'd0);
  assign wr_tx     = avs_write && (avs_address == 2'd1 || avs_address == 2'd2);
  assign wr_end    = avs_write && (avs_address == 2'd2);
  assign rd_rx     = avs_read && (avs_address == 2'd3);

  // Streams: a word moves exactly on a cycle where valid and ready are both high.
  assign tx_push     = wr_tx && !tx_full;
  assign tx_end_push = wr_end && !tx_full;
  assign tx_valid    = (state == SEND) && !tx_empty;
  assign {tx_last, tx_data} = tx_mem[tx_rp];
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_last_pop = tx_pop && tx_last;

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_rx && !rx_empty;

  assign tx_count_nxt = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign pkt_cnt_nxt  = pkt_cnt + CW'(tx_end_push) - CW'(tx_last_pop);

  assign rx_head_last = !rx_empty && rx_mem[rx_rp][DATA_W];
  assign status = {8'd0, 8'(tx_count), 8'(rx_count), irq_en, rx_underflow, tx_overflow,
                   rx_head_last, rx_empty, rx_full, tx_empty, tx_full};

  assign irq = irq_en && !rx_empty;

  always_ff @(posedge clk_clk) begin
    if (tx_push) tx_mem[tx_wp] <= {wr_end, avs_writedata};
    if (rx_push) rx_mem[rx_wp] <= {rx_last, rx_data};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_wp        <= '0;
      tx_rp        <= '0;
      rx_wp        <= '0;
      rx_rp        <= '0;
      tx_count     <= '0;
      rx_count     <= '0;
      pkt_cnt      <= '0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
      irq_en       <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      tx_count <= tx_count_nxt;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      pkt_cnt  <= pkt_cnt_nxt;

      if (wr_status) begin
        irq_en <= avs_writedata[7];
        if (avs_writedata[5]) tx_overflow  <= 1'b0;
        if (avs_writedata[6]) rx_underflow <= 1'b0;
      end
      if (wr_tx && tx_full)   tx_overflow  <= 1'b1;
      if (rd_rx && rx_empty)  rx_underflow <= 1'b1;

      if (avs_read) begin
        case (avs_address)
          2'd0:    avs_readdata <= DATA_W'(status);
          2'd3:    avs_readdata <= rx_pop ? rx_mem[rx_rp][DATA_W-1:0] : '0;
          default: avs_readdata <= '0;
        endcase
      end
    end
  end

  // Leaving a packet re-evaluates the start condition on the same edge, so consecutive
  // packets go out without a gap. A full FIFO forces sending to avoid deadlock.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else if (state == IDLE || tx_last_pop) begin
      state <= (pkt_cnt_nxt != '0 || tx_count_nxt == FULL_CNT) ? SEND : IDLE;
    end
  end

endmodule

// File: tb/tb_dircc_hps_mailbox.sv
// Directed and randomized bench for the HPS mailbox against a queue-based model of
// the register map, both FIFOs and the packet-ordered TX stream.
module tb_dircc_hps_mailbox;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [1:0]    avs_address;
  logic          avs_write;
  logic [W-1:0]  avs_writedata;
  logic          avs_read;
  logic [W-1:0]  avs_readdata;
  logic          irq;
  logic [W-1:0]  tx_data;
  logic          tx_last;
  logic          tx_valid;
  logic          tx_ready;
  logic [W-1:0]  rx_data;
  logic          rx_last;
  logic          rx_valid;
  logic          rx_ready;

  dircc_hps_mailbox #(.DATA_W(W), .DEPTH_LOG2(4)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .irq(irq),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk_clk = ~clk_clk;

  // Reference model: FIFO contents as queues of {last,data}, plus the register bits.
  logic [W:0] tx_q[$];
  logic [W:0] rx_q[$];
  logic       m_ovf, m_unf, m_irq_en;
  logic       rand_ready;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (tx_q.size() == D);
    s[1] = (tx_q.size() == 0);
    s[2] = (rx_q.size() == D);
    s[3] = (rx_q.size() == 0);
    s[4] = (rx_q.size() != 0) ? rx_q[0][W] : 1'b0;
    s[5] = m_ovf;
    s[6] = m_unf;
    s[7] = m_irq_en;
    s[15:8]  = 8'(rx_q.size());
    s[23:16] = 8'(tx_q.size());
    return s;
  endfunction

  // Every accepted fabric word must be the oldest word still held by the model.
  always @(negedge clk_clk) begin
    logic [W:0] e;
    if (reset_reset_n && tx_valid && tx_ready) begin
      e = 'x;
      if (tx_q.size() != 0) e = tx_q.pop_front();
      check("tx_word", {tx_last, tx_data}, e);
    end
  end

  always @(posedge clk_clk) begin
    if (rand_ready) begin
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic av_write(input logic [1:0] addr, input logic [W-1:0] data);
    avs_address = addr;
    avs_writedata = data;
    avs_write = 1'b1;
    step();
    avs_write = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] addr, output logic [W-1:0] data);
    avs_address = addr;
    avs_read = 1'b1;
    step();
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  task automatic tx_wr(input logic [W-1:0] data, input logic last);
    if (tx_q.size() == D) m_ovf = 1'b1;
    else tx_q.push_back({last, data});
    av_write(last ? 2'd2 : 2'd1, data);
  endtask

  task automatic rx_rd(input string tag);
    logic [W-1:0] d, e;
    logic [W:0]   h;
    av_read(2'd3, d);
    if (rx_q.size() != 0) begin
      h = rx_q.pop_front();
      e = h[W-1:0];
    end else begin
      e = '0;
      m_unf = 1'b1;
    end
    check(tag, d, e);
  endtask

  task automatic status_chk(input string tag, input logic [31:0] mask);
    logic [W-1:0] d;
    av_read(2'd0, d);
    check(tag, d & mask, exp_status() & mask);
  endtask

  task automatic rx_send(input logic [W-1:0] data, input logic last);
    int n;
    rx_data = data;
    rx_last = last;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      step();
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    else begin
      step();
      rx_q.push_back({last, data});
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input string tag);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(tag, tx_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] d, x;
    int len, nrx;

    reset_reset_n = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_last = 1'b0; rx_valid = 1'b0;
    rand_ready = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("rst_readdata", avs_readdata, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_rx_ready", rx_ready, 1);
    reset_reset_n = 1'b1;
    step();
    status_chk("rst_status", 32'hFFFF_FFFF);

    // Store-and-forward: nothing leaves until the packet end is written.
    tx_ready = 1'b1;
    tx_wr(32'h11, 1'b0);
    check("sf_hold1", tx_valid, 0);
    tx_wr(32'h22, 1'b0);
    check("sf_hold2", tx_valid, 0);
    tx_wr(32'h33, 1'b1);
    @(negedge clk_clk);
    check("sf_w0", {tx_valid, tx_last, tx_data}, {2'b10, 32'h11});
    @(negedge clk_clk);
    check("sf_w1", {tx_valid, tx_last, tx_data}, {2'b10, 32'h22});
    @(negedge clk_clk);
    check("sf_w2", {tx_valid, tx_last, tx_data}, {2'b11, 32'h33});
    @(negedge clk_clk);
    check("sf_idle", tx_valid, 0);
    step();

    // Overflow and forced cut-through on a full TX FIFO.
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) tx_wr(32'h100 + i, 1'b0);
    status_chk("ovf_status", 32'hFFFF_FFFF);
    check("ovf_forced_valid", tx_valid, 1);
    av_write(2'd0, 32'h20);
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    status_chk("ovf_w1c", 32'hFFFF_FFFF);
    tx_ready = 1'b1;
    wait_tx_drain("forced_drain");
    check("forced_empty_valid", tx_valid, 0);
    tx_wr(32'h99, 1'b1);
    wait_tx_drain("forced_end_drain");
    tx_wr(32'h55, 1'b0);
    step();
    check("idle_after_forced", tx_valid, 0);
    tx_wr(32'h66, 1'b1);
    wait_tx_drain("after_forced_pkt");

    // RX path, head last flag, underflow, read data hold.
    rx_send(32'hA, 1'b0);
    rx_send(32'hB, 1'b1);
    status_chk("rx_two_status", 32'hFFFF_FFFF);
    rx_rd("rx_read_a");
    status_chk("rx_head_last", 32'hFFFF_FFFF);
    rx_rd("rx_read_b");
    rx_rd("rx_read_empty");
    status_chk("rx_underflow", 32'hFFFF_FFFF);
    d = avs_readdata;
    av_write(2'd0, 32'h40);
    m_unf = 1'b0;
    check("readdata_hold", avs_readdata, d);
    av_read(2'd1, d);
    check("read_tx_data_reg", d, 0);
    status_chk("unf_w1c", 32'hFFFF_FFFF);

    // Interrupt follows irq_en and RX occupancy.
    av_write(2'd0, 32'h80);
    m_irq_en = 1'b1;
    check("irq_empty", irq, 0);
    rx_send(32'h5, 1'b1);
    check("irq_set", irq, 1);
    rx_rd("irq_pop_data");
    check("irq_clear", irq, 0);

    // Fill RX, then pop while the stream keeps offering a word.
    for (int i = 0; i < D; i++) rx_send($urandom(), 1'($urandom_range(0, 1)));
    check("rx_full_ready", rx_ready, 0);
    status_chk("rx_full_status", 32'hFFFF_FFFF);
    x = $urandom();
    rx_data = x;
    rx_last = 1'b1;
    rx_valid = 1'b1;
    rx_rd("rx_full_pop");
    step();
    rx_valid = 1'b0;
    rx_q.push_back({1'b1, x});
    check("rx_refill_ready", rx_ready, 0);
    status_chk("rx_refill_status", 32'hFFFF_FFFF);
    for (int i = 0; i < D; i++) rx_rd("rx_drain");
    status_chk("rx_drained_status", 32'hFFFF_FFFF);

    // Reset in the middle of sending a 5-word packet, with RX holding a word.
    rx_send(32'h77, 1'b0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) tx_wr(32'h200 + i, i == 4);
    check("mid_send_valid", tx_valid, 1);
    check("mid_irq", irq, 1);
    tx_ready = 1'b1;
    step();
    step();
    #2 reset_reset_n = 1'b0;
    #1;
    check("async_tx_valid", tx_valid, 0);
    check("async_irq", irq, 0);
    check("async_rx_ready", rx_ready, 1);
    check("async_readdata", avs_readdata, 0);
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0;
    tx_ready = 1'b0;
    step();
    reset_reset_n = 1'b1;
    step();
    status_chk("post_reset_status", 32'hFFFF_FFFF);

    // Randomized packets with a random fabric backpressure, interleaved with RX traffic.
    rand_ready = 1'b1;
    for (int p = 0; p < 14; p++) begin
      for (int n = 0; n < 300 && tx_q.size() > 8; n++) step();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) tx_wr($urandom(), i == len - 1);
      nrx = $urandom_range(1, 3);
      for (int i = 0; i < nrx; i++) rx_send($urandom(), 1'($urandom_range(0, 1)));
      for (int i = 0; i < nrx; i++) begin
        status_chk("rnd_rx_status", 32'h0000_FFFC);
        rx_rd("rnd_rx_data");
      end
    end
    rand_ready = 1'b0;
    step();
    tx_ready = 1'b1;
    wait_tx_drain("rnd_tx_drain");
    step();
    check("rnd_end_valid", tx_valid, 0);
    status_chk("rnd_end_status", 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
